lzrw1_decomp_sequencer: RTL

Sequences the LZRW1 decompressor from the compressor's output buffers once compression finishes. Walks the control-word bit array and compressed byte array through registered read ports, assembles each item, and issues it to the decompressor's `data_in` / `control_word_in` / `data_in_valid` inputs, pacing on `decompressor_busy`. Sits between the compressor buffers and `decompressor_top` in the combined top level, and replaces ad-hoc pointer logic there.

---
 rtl/lzrw1_pkg.sv | 9 +
 rtl/lzrw1_decomp_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/lzrw1_pkg.sv
// lzrw1_pkg: constants and sequencer state type shared by the LZRW1 compressor, decompressor and sequencer
package lzrw1_pkg;
  localparam int DEFAULT_STRINGSIZE = 4096;
  localparam logic ITEM_LITERAL = 1'b0;
  localparam logic ITEM_COPY = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE, S_RD_CTRL, S_RD_B0, S_RD_B1, S_ISSUE, S_GAP, S_DRAIN
  } lzrw1_seq_state_t;
endpackage

// File: rtl/lzrw1_decomp_sequencer.sv
// lzrw1_decomp_sequencer: feeds compressor buffers item by item into the LZRW1 decompressor
// Optional LZRW1_SEQ_BOUNDS_CHECK_EN aborts a run whose next item would read past byte_count.
module lzrw1_decomp_sequencer
  import lzrw1_pkg::*;
#(
  parameter int STRINGSIZE = DEFAULT_STRINGSIZE,
  localparam int ADDR_W = $clog2(STRINGSIZE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   item_count,
  input  logic [ADDR_W:0]   byte_count,
  output logic              ctrl_rd,
  output logic [ADDR_W-1:0] ctrl_addr,
  input  logic              ctrl_bit,
  output logic              data_rd,
  output logic [ADDR_W-1:0] data_addr,
  input  logic [7:0]        data_byte,
  output logic [15:0]       d_data_in,
  output logic              d_control_word_in,
  output logic              d_data_in_valid,
  input  logic              decompressor_busy,
  output logic              busy,
  output logic              done,
  output logic              error
);
  lzrw1_seq_state_t r_state, w_next;
  logic [ADDR_W:0] r_item_idx, r_byte_ptr, w_size, w_ptr_p1;
  logic [7:0] r_b0, r_b1, w_cur;
  logic r_type, r_fresh, r_error, w_oob, w_issue;
  assign w_size = {{(ADDR_W-1){1'b0}}, ctrl_bit, ~ctrl_bit};
  assign w_ptr_p1 = r_byte_ptr + {{ADDR_W{1'b0}}, 1'b1};
`ifdef LZRW1_SEQ_BOUNDS_CHECK_EN
  assign w_oob = ({1'b0, r_byte_ptr} + {1'b0, w_size}) > {1'b0, byte_count};
`else
  logic w_unused_byte_count;
  assign w_unused_byte_count = ^byte_count;
  assign w_oob = 1'b0;
`endif
  // The last byte arrives on the read bus in the first ISSUE cycle; later cycles replay the captured copy
  assign w_cur = r_fresh ? data_byte : (r_type ? r_b1 : r_b0);
  assign w_issue = (r_state == S_ISSUE) && !decompressor_busy;
  assign busy = (r_state != S_IDLE);
  assign error = r_error;
  always_comb begin
    w_next = r_state;
    ctrl_rd = 1'b0;
    ctrl_addr = '0;
    data_rd = 1'b0;
    data_addr = '0;
    d_data_in = 16'h0000;
    d_control_word_in = 1'b0;
    d_data_in_valid = 1'b0;
    done = 1'b0;
    case (r_state)
      S_IDLE: w_next = !start ? S_IDLE : (item_count == '0 ? S_DRAIN : S_RD_CTRL);
      S_RD_CTRL: begin
        ctrl_rd = 1'b1;
        ctrl_addr = r_item_idx[ADDR_W-1:0];
        w_next = S_RD_B0;
      end
      S_RD_B0: begin
        data_rd = !w_oob;
        data_addr = w_oob ? '0 : r_byte_ptr[ADDR_W-1:0];
        done = w_oob;
        w_next = w_oob ? S_IDLE : (ctrl_bit ? S_RD_B1 : S_ISSUE);
      end
      S_RD_B1: begin
        data_rd = 1'b1;
        data_addr = w_ptr_p1[ADDR_W-1:0];
        w_next = S_ISSUE;
      end
      S_ISSUE: begin
        d_data_in = r_type ? {r_b0, w_cur} : {8'h00, w_cur};
        d_control_word_in = r_type;
        d_data_in_valid = !decompressor_busy;
        w_next = decompressor_busy ? S_ISSUE : S_GAP;
      end
      S_GAP: w_next = (r_item_idx < item_count) ? S_RD_CTRL : S_DRAIN;
      S_DRAIN: begin
        done = !decompressor_busy;
        w_next = decompressor_busy ? S_DRAIN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_item_idx <= '0;
      r_byte_ptr <= '0;
      r_b0 <= 8'h00;
      r_b1 <= 8'h00;
      r_type <= ITEM_LITERAL;
      r_fresh <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fresh <= (w_next == S_ISSUE) && (r_state != S_ISSUE);
      if (r_state == S_IDLE && start) begin
        r_item_idx <= '0;
        r_byte_ptr <= '0;
        r_error <= 1'b0;
      end
      if (r_state == S_RD_B0) begin
        r_type <= ctrl_bit;
        if (w_oob) r_error <= 1'b1;
      end
      if (r_state == S_RD_B1) r_b0 <= data_byte;
      if (r_state == S_ISSUE && r_fresh) begin
        if (r_type == ITEM_COPY) r_b1 <= data_byte;
        else r_b0 <= data_byte;
      end
      if (w_issue) begin
        r_byte_ptr <= r_byte_ptr + (r_type ? {{(ADDR_W-1){1'b0}}, 2'd2} : {{ADDR_W{1'b0}}, 1'b1});
        r_item_idx <= r_item_idx + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end
endmodule
